// File: rtl/bilinear_tap_mac_if.sv
// Tap-input and pixel-output handshake bundle for bilinear_tap_mac.
// slave = the MAC stage, master = the upstream/downstream driver.
interface bilinear_tap_mac_if #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8
);
  logic             tap_valid;
  logic             tap_ready;
  logic [PIX_W-1:0] tap_pixel;
  logic [WGT_W-1:0] tap_weight;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             busy;

  modport master (
    output tap_valid, tap_pixel, tap_weight, out_ready,
    input  tap_ready, out_valid, out_pixel, busy
  );

  modport slave (
    input  tap_valid, tap_pixel, tap_weight, out_ready,
    output tap_ready, out_valid, out_pixel, busy
  );
endinterface

// File: rtl/bilinear_tap_mac.sv
// Serial shift-and-add MAC of TAPS (pixel,weight) taps -> one rounded, saturated pixel; WGT_W+1 cycles per tap plus ROUND.
// Optional macro BILIN_ROUND_EN: round-half-up in ROUND, otherwise truncation with identical latency; holds output until out_ready.
module bilinear_tap_mac #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8,
  parameter int TAPS  = 4,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  bilinear_tap_mac_if.slave    bus
);
  localparam int BIT_W = (WGT_W > 1) ? $clog2(WGT_W) : 1;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int SCL_W = ACC_W - WGT_W;

  typedef enum logic [1:0] {S_LOAD, S_MUL, S_ROUND, S_OUT} state_t;

  state_t             state_q;
  logic [PIX_W-1:0]   pix_q;
  logic [WGT_W-1:0]   wgt_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [TAP_W-1:0]   tap_cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic               tap_ready_q;
  logic               out_valid_q;
  logic               busy_q;
  logic [PIX_W-1:0]   out_pixel_q;

  logic [ACC_W-1:0]   add_b;
  logic [ACC_W-1:0]   add_sum;
  logic               unused_co;
  logic [SCL_W-1:0]   scaled;
  logic [PIX_W-1:0]   sat_d;

  // Adder operand: the shifted partial product in MUL, the rounding constant in ROUND, zero otherwise.
  always_comb begin
    add_b = '0;
    if (state_q == S_MUL && wgt_q[bit_cnt_q]) begin
      add_b = ACC_W'(pix_q) << bit_cnt_q;
    end
`ifdef BILIN_ROUND_EN
    if (state_q == S_ROUND) begin
      add_b = ACC_W'(1) << (WGT_W - 1);
    end
`endif
  end

  adder_20b u_add (
    .a_i    (acc_q),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (unused_co)
  );

  // Output pixel is taken from the ROUND-cycle sum so it is registered on entry to OUT.
  always_comb begin
    scaled = add_sum[ACC_W-1:WGT_W];
    sat_d  = (|scaled[SCL_W-1:PIX_W]) ? {PIX_W{1'b1}} : scaled[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      pix_q       <= '0;
      wgt_q       <= '0;
      bit_cnt_q   <= '0;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      tap_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (bus.tap_valid) begin
            pix_q       <= bus.tap_pixel;
            wgt_q       <= bus.tap_weight;
            bit_cnt_q   <= '0;
            if (tap_cnt_q == '0) acc_q <= '0;
            tap_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q     <= add_sum;
          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(WGT_W - 1)) begin
            if (tap_cnt_q == TAP_W'(TAPS - 1)) begin
              state_q <= S_ROUND;
            end else begin
              tap_cnt_q   <= tap_cnt_q + TAP_W'(1);
              tap_ready_q <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
        end
        S_ROUND: begin
          acc_q       <= add_sum;
          out_pixel_q <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            tap_cnt_q   <= '0;
            tap_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.tap_ready = tap_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.busy      = busy_q;
endmodule

// 20-bit ripple-carry adder shared as the MAC datapath adder.
module adder_20b (
  input  logic [19:0] a_i,
  input  logic [19:0] b_i,
  input  logic        cin_i,
  output logic [19:0] sum_o,
  output logic        cout_o
);
  always_comb begin
    logic carry;
    sum_o = '0;
    carry = cin_i;
    for (int i = 0; i < 20; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end
endmodule

// File: tb/tb_bilinear_tap_mac.sv
// Directed bench for bilinear_tap_mac with an expected-pixel scoreboard.
module tb_bilinear_tap_mac;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   exp_q[$];

  bilinear_tap_mac_if #(.PIX_W(8), .WGT_W(8)) bus ();

  bilinear_tap_mac #(.PIX_W(8), .WGT_W(8), .TAPS(4), .ACC_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact dot product, optional half-LSB rounding, scale by 2^8, saturate.
  function automatic int model(input logic [3:0][7:0] p, input logic [3:0][7:0] w);
    int acc;
    int v;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += int'(p[i]) * int'(w[i]);
`ifdef BILIN_ROUND_EN
    acc += 128;
`endif
    v = acc >> 8;
    return (v > 255) ? 255 : v;
  endfunction

  // Called at a negedge. Back-to-back mode keeps tap_valid high with the next tap during MUL.
  task automatic feed(input logic [3:0][7:0] p, input logic [3:0][7:0] w,
                      input int idle, input int ntaps, output int hs0);
    int n;
    hs0 = 0;
    for (int i = 0; i < ntaps; i++) begin
      bus.tap_pixel  = p[i];
      bus.tap_weight = w[i];
      n = 0;
      while (!bus.tap_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("tap_accept_ready", {31'd0, bus.tap_ready}, 32'd1);
      if (i > 0 && idle > 0) begin
        repeat (idle) @(negedge clk);
      end
      bus.tap_valid = 1'b1;
      if (i == 0) hs0 = cyc;
      @(negedge clk);
      if (idle > 0 || i == ntaps - 1) bus.tap_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int hs0, input int exp_lat, input int hold);
    int n;
    int exp;
    n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", {31'd0, bus.out_valid}, 32'd1);
    check("out_latency", cyc - hs0, exp_lat);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check("out_pixel", {24'd0, bus.out_pixel}, exp);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_out_pixel", {24'd0, bus.out_pixel}, exp);
        check("hold_tap_ready", {31'd0, bus.tap_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_tap_ready", {31'd0, bus.tap_ready}, 32'd1);
    check("post_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [3:0][7:0] p;
    logic [3:0][7:0] w;
    int hs0;

    rst            = 1'b1;
    bus.tap_valid  = 1'b0;
    bus.tap_pixel  = '0;
    bus.tap_weight = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_tap_ready", {31'd0, bus.tap_ready}, 32'd1);
    check("rst_busy",      {31'd0, bus.busy}, 32'd0);
    check("rst_out_pixel", {24'd0, bus.out_pixel}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Uniform taps, back-to-back.
    p = {8'd100, 8'd100, 8'd100, 8'd100};
    w = {8'd64, 8'd64, 8'd64, 8'd64};
    exp_q.push_back(model(p, w));
    feed(p, w, 0, 4, hs0);
    check("mul_busy", {31'd0, bus.busy}, 32'd1);
    check("mul_tap_ready", {31'd0, bus.tap_ready}, 32'd0);
    wait_out(hs0, 37, 0);

    // Mixed taps: rounding-sensitive result.
    p = {8'd40, 8'd30, 8'd20, 8'd10};
    w = {8'd32, 8'd32, 8'd64, 8'd128};
    exp_q.push_back(model(p, w));
    feed(p, w, 0, 4, hs0);
    wait_out(hs0, 37, 0);

    // Saturation.
    p = {8'd255, 8'd255, 8'd255, 8'd255};
    w = {8'd255, 8'd255, 8'd255, 8'd255};
    exp_q.push_back(model(p, w));
    feed(p, w, 0, 4, hs0);
    wait_out(hs0, 37, 0);

    // All-zero weights.
    p = {8'd200, 8'd150, 8'd100, 8'd50};
    w = {8'd0, 8'd0, 8'd0, 8'd0};
    exp_q.push_back(model(p, w));
    feed(p, w, 0, 4, hs0);
    wait_out(hs0, 37, 0);

    // Downstream backpressure for 10 cycles.
    p = {8'd40, 8'd30, 8'd20, 8'd10};
    w = {8'd32, 8'd32, 8'd64, 8'd128};
    bus.out_ready = 1'b0;
    exp_q.push_back(model(p, w));
    feed(p, w, 0, 4, hs0);
    wait_out(hs0, 37, 10);

    // Reset during MUL of the third tap; the aborted group must leave no trace.
    p = {8'd250, 8'd250, 8'd250, 8'd250};
    w = {8'd200, 8'd200, 8'd200, 8'd200};
    feed(p, w, 0, 3, hs0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_tap_ready", {31'd0, bus.tap_ready}, 32'd1);
    check("abort_busy",      {31'd0, bus.busy}, 32'd0);
    p = {8'd200, 8'd200, 8'd200, 8'd200};
    w = {8'd64, 8'd64, 8'd64, 8'd64};
    exp_q.push_back(model(p, w));
    feed(p, w, 0, 4, hs0);
    wait_out(hs0, 37, 0);

    // Three idle LOAD cycles before each of taps 1..3.
    p = {8'd40, 8'd30, 8'd20, 8'd10};
    w = {8'd32, 8'd32, 8'd64, 8'd128};
    exp_q.push_back(model(p, w));
    feed(p, w, 3, 4, hs0);
    wait_out(hs0, 46, 0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
